// File: rtl/sort4_run_merger.sv
// ---------------------------------------------------------------------------
// sort4_run_merger
//
// Downstream stage of the 4-element sequence sorter. It collects two
// consecutive sorted runs of RUN_LEN elements (run A, then run B) from a
// serial one-element-per-cycle stream. It then streams them back out as a
// single merged run of 2*RUN_LEN elements, in nondecreasing order. Any input
// run that was not itself nondecreasing raises a sticky error flag. The
// merge still proceeds on such a run, so the output stays deterministic.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   in_data holds a valid element
//   in_data    input element (unsigned), arriving as sorted runs of RUN_LEN
//   in_ready   high while filling; an element is taken on in_valid&&in_ready
//   out_valid  high while merging; out_data holds the selected element
//   out_data   merged element, forced to 0 whenever out_valid is low
//   out_last   marks the final element of each 2*RUN_LEN merged run
//   out_ready  downstream takes out_data on out_valid&&out_ready
//   order_err  sticky: some input run was not nondecreasing (cleared by rst)
// ---------------------------------------------------------------------------
module sort4_run_merger #(
    parameter int DATA_WIDTH = 9,
    parameter int RUN_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  order_err
);

    localparam int IW = $clog2(RUN_LEN);

    localparam logic [1:0] FILL_A = 2'd0;
    localparam logic [1:0] FILL_B = 2'd1;
    localparam logic [1:0] MERGE  = 2'd2;

    // Read indices carry one extra bit so that "buffer exhausted"
    // (index == RUN_LEN) is representable.
    localparam logic [IW:0]   RUN_END  = (IW+1)'(RUN_LEN);
    localparam logic [IW:0]   LAST_SUM = (IW+1)'(2*RUN_LEN-1);
    localparam logic [IW:0]   IDX_ONE  = (IW+1)'(1);
    localparam logic [IW-1:0] WI_LAST  = IW'(RUN_LEN-1);
    localparam logic [IW-1:0] WI_ONE   = IW'(1);

    logic [1:0]            state;
    logic [IW-1:0]         wi;
    logic [IW:0]           ia;
    logic [IW:0]           ib;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] buf_a [RUN_LEN];
    logic [DATA_WIDTH-1:0] buf_b [RUN_LEN];

    logic [DATA_WIDTH-1:0] a_head;
    logic [DATA_WIDTH-1:0] b_head;
    logic                  sel_a;
    logic                  merging;
    logic                  in_fire;
    logic                  out_fire;

    // Head-of-buffer selection for the merge. When an index has reached
    // RUN_LEN, its low bits wrap to 0. That read is harmless because
    // sel_a already ignores an exhausted side. The <= makes ties take A
    // first, so the merge is stable.
    always_comb begin
        a_head   = buf_a[ia[IW-1:0]];
        b_head   = buf_b[ib[IW-1:0]];
        sel_a    = (ia < RUN_END) && ((ib == RUN_END) || (a_head <= b_head));
        merging  = (state == MERGE);
        in_ready = (state == FILL_A) || (state == FILL_B);
        out_valid = merging;
        out_data = '0;
        if (merging) begin
            out_data = sel_a ? a_head : b_head;
        end
        out_last = merging && ((ia + ib) == LAST_SUM);
        in_fire  = in_valid && in_ready;
        out_fire = merging && out_ready;
    end

    // Element storage has no reset. Nothing is read out before it is
    // written, so the buffers only need a clock and a write enable.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            if (state == FILL_A) begin
                buf_a[wi] <= in_data;
            end else begin
                buf_b[wi] <= in_data;
            end
        end
    end

    // Control: fill A, fill B, then merge until the last element leaves.
    // The order check compares each element with its predecessor in the
    // same run. The first element of a run (wi == 0) is never checked, so
    // there is no comparison across run boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL_A;
            wi        <= '0;
            ia        <= '0;
            ib        <= '0;
            prev      <= '0;
            order_err <= 1'b0;
        end else begin
            if (in_fire) begin
                prev <= in_data;
                if ((wi != '0) && (in_data < prev)) begin
                    order_err <= 1'b1;
                end
            end
            case (state)
                FILL_A: begin
                    if (in_fire) begin
                        if (wi == WI_LAST) begin
                            wi    <= '0;
                            state <= FILL_B;
                        end else begin
                            wi <= wi + WI_ONE;
                        end
                    end
                end
                FILL_B: begin
                    if (in_fire) begin
                        if (wi == WI_LAST) begin
                            wi    <= '0;
                            ia    <= '0;
                            ib    <= '0;
                            state <= MERGE;
                        end else begin
                            wi <= wi + WI_ONE;
                        end
                    end
                end
                MERGE: begin
                    if (out_fire) begin
                        if (sel_a) begin
                            ia <= ia + IDX_ONE;
                        end else begin
                            ib <= ib + IDX_ONE;
                        end
                        if (out_last) begin
                            state <= FILL_A;
                        end
                    end
                end
                default: begin
                    state <= FILL_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort4_run_merger.sv
// ---------------------------------------------------------------------------
// tb_sort4_run_merger
//
// Directed bench for sort4_run_merger (DATA_WIDTH=9, RUN_LEN=4). Inputs
// change on the falling edge of tb_clk. Outputs are sampled at that same
// falling edge, so each step sees the state left by the previous rising
// edge. Expected values are hand-computed merges of the vectors fed in.
// ---------------------------------------------------------------------------
module tb_sort4_run_merger;

    logic       tb_clk;
    logic       rst;
    logic       in_valid;
    logic [8:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [8:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       order_err;

    int compared;
    int mismatched;

    sort4_run_merger #(
        .DATA_WIDTH(9),
        .RUN_LEN   (4)
    ) dut (
        .clk      (tb_clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(out_ready),
        .order_err(order_err)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // One comparison: count it, and on a miss count and report it.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Offer one element for the coming rising edge. The outputs checked
    // here reflect the state before this element is taken.
    task automatic apply_stimulus(input logic [8:0] value, input logic exp_err);
        @(negedge tb_clk);
        in_valid = 1'b1;
        in_data  = value;
        check_output("fill_in_ready", 32'(in_ready), 32'd1);
        check_output("fill_out_valid", 32'(out_valid), 32'd0);
        check_output("fill_order_err", 32'(order_err), 32'(exp_err));
    endtask

    // A cycle with in_valid low while filling. The block must keep waiting.
    task automatic idle_cycle();
        @(negedge tb_clk);
        in_valid = 1'b0;
        check_output("gap_in_ready", 32'(in_ready), 32'd1);
        check_output("gap_out_valid", 32'(out_valid), 32'd0);
    endtask

    // Accept one merged element. A junk input stays offered during the
    // merge (it must be ignored) and is withdrawn on the last element.
    task automatic pop_expect(input logic [8:0] value, input logic last);
        @(negedge tb_clk);
        out_ready = 1'b1;
        in_valid  = ~last;
        in_data   = 9'h1AA;
        check_output("merge_out_valid", 32'(out_valid), 32'd1);
        check_output("merge_in_ready", 32'(in_ready), 32'd0);
        check_output("merge_out_data", 32'(out_data), 32'(value));
        check_output("merge_out_last", 32'(out_last), 32'(last));
    endtask

    // A downstream stall: the current element must be held unchanged.
    task automatic stall_expect(input logic [8:0] value);
        @(negedge tb_clk);
        out_ready = 1'b0;
        check_output("stall_out_valid", 32'(out_valid), 32'd1);
        check_output("stall_in_ready", 32'(in_ready), 32'd0);
        check_output("stall_out_data", 32'(out_data), 32'(value));
        check_output("stall_out_last", 32'(out_last), 32'd0);
    endtask

    // Back in FILL_A after a completed merge.
    task automatic check_idle(input logic exp_err);
        @(negedge tb_clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_output("idle_in_ready", 32'(in_ready), 32'd1);
        check_output("idle_out_valid", 32'(out_valid), 32'd0);
        check_output("idle_out_data", 32'(out_data), 32'd0);
        check_output("idle_out_last", 32'(out_last), 32'd0);
        check_output("idle_order_err", 32'(order_err), 32'(exp_err));
    endtask

    task automatic feed_case1();
        apply_stimulus(9'd3, 1'b0);
        apply_stimulus(9'd7, 1'b0);
        apply_stimulus(9'd12, 1'b0);
        apply_stimulus(9'd200, 1'b0);
        apply_stimulus(9'd1, 1'b0);
        apply_stimulus(9'd7, 1'b0);
        apply_stimulus(9'd9, 1'b0);
        apply_stimulus(9'd511, 1'b0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;

        // Reset state
        #12;
        check_idle(1'b0);
        rst = 1'b0;

        // Case 1: interleaved merge with a tie
        $display("[TB] case 1: interleaved merge");
        feed_case1();
        pop_expect(9'd1, 1'b0);
        pop_expect(9'd3, 1'b0);
        pop_expect(9'd7, 1'b0);
        pop_expect(9'd7, 1'b0);
        pop_expect(9'd9, 1'b0);
        pop_expect(9'd12, 1'b0);
        pop_expect(9'd200, 1'b0);
        pop_expect(9'd511, 1'b1);
        check_idle(1'b0);

        // Case 2: A exhausts first, then B drains
        $display("[TB] case 2: A exhausts first");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(9'(i), 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            pop_expect(9'(i), (i == 7));
        end
        check_idle(1'b0);

        // Case 3: out_ready low on merge cycles 2 and 3
        $display("[TB] case 3: output backpressure");
        feed_case1();
        pop_expect(9'd1, 1'b0);
        stall_expect(9'd3);
        stall_expect(9'd3);
        pop_expect(9'd3, 1'b0);
        pop_expect(9'd7, 1'b0);
        pop_expect(9'd7, 1'b0);
        pop_expect(9'd9, 1'b0);
        pop_expect(9'd12, 1'b0);
        pop_expect(9'd200, 1'b0);
        pop_expect(9'd511, 1'b1);
        check_idle(1'b0);

        // Case 4: unsorted run A; the flag rises on 2 and stays high
        $display("[TB] case 4: unsorted run");
        apply_stimulus(9'd5, 1'b0);
        apply_stimulus(9'd2, 1'b0);
        apply_stimulus(9'd8, 1'b1);
        apply_stimulus(9'd9, 1'b1);
        apply_stimulus(9'd1, 1'b1);
        apply_stimulus(9'd1, 1'b1);
        apply_stimulus(9'd1, 1'b1);
        apply_stimulus(9'd1, 1'b1);
        pop_expect(9'd1, 1'b0);
        pop_expect(9'd1, 1'b0);
        pop_expect(9'd1, 1'b0);
        pop_expect(9'd1, 1'b0);
        pop_expect(9'd5, 1'b0);
        pop_expect(9'd2, 1'b0);
        pop_expect(9'd8, 1'b0);
        pop_expect(9'd9, 1'b1);
        check_idle(1'b1);

        // Case 5: reset after three outputs. The error from case 4 must
        // be cleared as well.
        $display("[TB] case 5: reset mid-merge");
        apply_stimulus(9'd3, 1'b1);
        apply_stimulus(9'd7, 1'b1);
        apply_stimulus(9'd12, 1'b1);
        apply_stimulus(9'd200, 1'b1);
        apply_stimulus(9'd1, 1'b1);
        apply_stimulus(9'd7, 1'b1);
        apply_stimulus(9'd9, 1'b1);
        apply_stimulus(9'd511, 1'b1);
        pop_expect(9'd1, 1'b0);
        pop_expect(9'd3, 1'b0);
        pop_expect(9'd7, 1'b0);
        @(negedge tb_clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        check_output("rst_order_err", 32'(order_err), 32'd0);
        check_output("rst_out_data", 32'(out_data), 32'd0);
        @(negedge tb_clk);
        rst = 1'b0;
        apply_stimulus(9'd10, 1'b0);
        apply_stimulus(9'd20, 1'b0);
        apply_stimulus(9'd30, 1'b0);
        apply_stimulus(9'd40, 1'b0);
        apply_stimulus(9'd15, 1'b0);
        apply_stimulus(9'd25, 1'b0);
        apply_stimulus(9'd35, 1'b0);
        apply_stimulus(9'd45, 1'b0);
        pop_expect(9'd10, 1'b0);
        pop_expect(9'd15, 1'b0);
        pop_expect(9'd20, 1'b0);
        pop_expect(9'd25, 1'b0);
        pop_expect(9'd30, 1'b0);
        pop_expect(9'd35, 1'b0);
        pop_expect(9'd40, 1'b0);
        pop_expect(9'd45, 1'b1);
        check_idle(1'b0);

        // Case 6: input gaps and boundary values 0 / 511
        $display("[TB] case 6: input stall and boundary values");
        apply_stimulus(9'd0, 1'b0);
        idle_cycle();
        apply_stimulus(9'd0, 1'b0);
        idle_cycle();
        apply_stimulus(9'd511, 1'b0);
        idle_cycle();
        apply_stimulus(9'd511, 1'b0);
        idle_cycle();
        apply_stimulus(9'd0, 1'b0);
        idle_cycle();
        apply_stimulus(9'd511, 1'b0);
        idle_cycle();
        apply_stimulus(9'd511, 1'b0);
        idle_cycle();
        apply_stimulus(9'd511, 1'b0);
        pop_expect(9'd0, 1'b0);
        pop_expect(9'd0, 1'b0);
        pop_expect(9'd0, 1'b0);
        pop_expect(9'd511, 1'b0);
        pop_expect(9'd511, 1'b0);
        pop_expect(9'd511, 1'b0);
        pop_expect(9'd511, 1'b0);
        pop_expect(9'd511, 1'b1);
        check_idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sort4_run_merger.md
Name: sort4_run_merger

Overview:
- Downstream stage of the 4-element sequence sorter.
- Consumes the sorter's serial output stream, one element per cycle, as consecutive sorted runs of RUN_LEN elements.
- Buffers two consecutive runs and emits them as one merged, sorted run of 2*RUN_LEN elements, flagging any input run that arrived unsorted.
- Output feeds the file-dump/check logic in the same serial one-element-per-cycle format.

Parameters:
DATA_WIDTH, 9, element width in bits; unsigned.
RUN_LEN, 4, elements per input run; power of 2, range 2..16.

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data holds a valid element
in_data  input  DATA_WIDTH  input element, sorted runs of RUN_LEN
in_ready  output  1  block can accept an element this cycle
out_valid  output  1  out_data holds a valid merged element
out_data  output  DATA_WIDTH  merged element, nondecreasing within a 2*RUN_LEN run
out_last  output  1  high with the final element of each merged run
out_ready  input  1  downstream accepts out_data this cycle
order_err  output  1  sticky flag: an input run was not nondecreasing

Behaviour:
- Clocking and reset: one clock clk; reset rst is asynchronous and active-high.
- Reset state: FILL_A, all indices 0, order_err=0.
- Output reset values: in_ready=1, out_valid=0, out_data=0, out_last=0.
- Input transfer: occurs on a clk edge with in_valid && in_ready.
- Output transfer: occurs on a clk edge with out_valid && out_ready.
- Storage: buffers A[0..RUN_LEN-1] and B[0..RUN_LEN-1].
- Write index: wi, log2(RUN_LEN) bits.
- Read indices: ia and ib, each log2(RUN_LEN)+1 bits.
- FILL_A:
  - in_ready=1, out_valid=0.
  - Each input transfer writes A[wi] and increments wi.
  - On the transfer with wi==RUN_LEN-1: wi wraps to 0, go to FILL_B.
- FILL_B: identical, writing B. On its last transfer: ia=ib=0, go to MERGE.
- MERGE:
  - in_ready=0, out_valid=1.
  - Selection: if ia<RUN_LEN and (ib==RUN_LEN or A[ia]<=B[ib]), select A[ia], otherwise select B[ib].
  - Ties take A first (stable merge). Comparison is unsigned.
  - out_data = selected element, driven combinationally from buffers/indices and held stable while out_ready=0.
  - On an output transfer, increment ia or ib for the selected buffer.
  - out_last=1 when ia+ib==2*RUN_LEN-1.
  - On the transfer with out_last=1: go to FILL_A.
- out_data is forced to 0 whenever out_valid=0.
- Latency: the first merged element is valid the cycle after the final B input transfer. With out_ready held high, a full cycle is RUN_LEN*2 input cycles plus RUN_LEN*2 output cycles.
- Order check:
  - Within each run, a register holds the previous element.
  - For the 2nd..RUN_LEN-th transfer of a run, in_data < prev sets order_err=1.
  - The first element of a run is never compared against the prior run.
  - order_err is cleared only by rst.
- Unsorted input is still merged by the rule above; the output is then deterministic but not guaranteed sorted.
- Backpressure:
  - in_valid low in FILL states stalls filling without loss.
  - out_ready low in MERGE holds all state.
- Inputs presented during MERGE are not accepted (in_ready=0); upstream must hold them.
- Reset asserted mid-operation: immediate return to the reset state.
  - Partial runs and buffer contents are discarded.
  - out_valid drops asynchronously.
  - The first accepted input after deassertion is A[0].
- Buffer contents need no reset value; they are never output before being written.
- All index arithmetic is modulo the stated widths; no overflow is reachable in legal operation.

Test Plan:
1. Interleaved merge with tie. Stimulus: rst pulse, out_ready=1, in_valid=1 with 3,7,12,200 then 1,7,9,511. Required: out_data 1,3,7,7,9,12,200,511. The first 7 comes from A. out_last high only on 511. order_err=0.
2. One buffer exhausts first. Stimulus: A=0,1,2,3, B=4,5,6,7. Required: out 0..7 in order, with B drained after ia reaches 4. Next cycle back in FILL_A with in_ready=1.
3. Backpressure. Stimulus: case 1 with out_ready low on cycles 2 and 3 of MERGE. Required: out_data held at 3 across the stall, same 8-value sequence, no duplicates or drops. in_ready stays 0 throughout MERGE.
4. Unsorted run. Stimulus: A=5,2,8,9, B=1,1,1,1. Required: order_err rises on the edge accepting 2 and stays high after a subsequent sorted pair. Output 1,1,1,1,5,2,8,9.
5. Reset mid-merge. Stimulus: rst asserted after 3 outputs of case 1. Required: out_valid=0, in_ready=1 and order_err=0 immediately. Then feeding 10,20,30,40 / 15,25,35,45 yields 10,15,20,25,30,35,40,45.
6. Input stall and boundary values. Stimulus: in_valid toggling 1,0,1,0 while feeding A=0,0,511,511 and B=0,511,511,511. Required: gaps absorbed, output 0,0,0,511,511,511,511,511 with last on the 8th element.
